scr1_trace_buf: RTL
===================

# scr1_trace_buf

Synthesizable commit-trace buffer for the SCR1 pipeline. It sits beside the simulation-only tracelog on the same EXU/MPRF commit signals. It packs each commit event (PC, register-file write) into a fixed-width record and queues it in a small FIFO. Records drain over a valid/ready stream to an on-chip trace sink or debug port. When the FIFO overflows, commit events are dropped and counted, and a single overflow-marker record carrying the drop count is inserted once space returns.

## Interface
- FIFO_DEPTH, 8, number of record entries; power of 2, range 2..64
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- trace_en  in  1  capture enable; low = no new events captured, FIFO keeps draining
- update_pc_en  in  1  EXU PC update (instruction commit) strobe
- update_pc  in  32  PC value for that update
- mprf_wr_en  in  1  MPRF write strobe
- mprf_wr_addr  in  5  MPRF write address
- mprf_wr_data  in  32  MPRF write data
- trc_vd  out  1  head record valid
- trc_rdy  in  1  sink ready; pop when trc_vd & trc_rdy
- trc_data  out  72 (104 with timestamp)  head record
- trc_ovf_sticky  out  1  set on any drop, held until cleared
- trc_ovf_clr  in  1  synchronous clear of trc_ovf_sticky

## Operation
- Event: trace_en & (update_pc_en | mprf_wr_en) in a cycle.
- Record fields:
  - [31:0] update_pc
  - [63:32] mprf_wr_data
  - [68:64] mprf_wr_addr
  - [69] wr_flag = mprf_wr_en & (mprf_wr_addr != 0)
  - [70] ovf marker
  - [71] reserved 0
  - When wr_flag = 0, data and addr fields are 0.
- Marker record:
  - [70] = 1
  - [31:0] = {16'b0, drop_cnt}
  - [69:32] = 0
  - [71] = 0
- FIFO: single write port, show-ahead read. trc_data is driven from the head entry.
- Space rule: a write is accepted only if occupancy < FIFO_DEPTH at the start of the cycle. A same-cycle pop does not free a slot.
- Simultaneous push and pop with 0 < occupancy < FIFO_DEPTH: occupancy unchanged.
- drop_cnt: 16-bit, saturates at 0xFFFF, cleared when the marker is pushed.
- State machine:
  - NORMAL:
    - Event with space: push event record.
    - Event without space: drop it, drop_cnt = 1, set sticky, go to OVF.
  - OVF:
    - No space: each event increments drop_cnt (saturating).
    - Space available: push marker, go to NORMAL.
    - An event in the marker cycle is also dropped and included in the marker count (marker carries drop_cnt+1, saturating).
  - trace_en low in OVF: the marker is still emitted when space appears.
- trc_ovf_sticky: a set in the same cycle as trc_ovf_clr wins.
- Reset mid-operation: FIFO emptied, in-flight records lost, state returns to NORMAL.

## Timing
- Reset values:
  - trc_vd = 0, trc_data = 0, trc_ovf_sticky = 0
  - occupancy = 0, drop_cnt = 0, state = NORMAL
  - timestamp = 0
- Latency: event in cycle N into an empty FIFO gives trc_vd = 1 in cycle N+1 with that record on trc_data.
- trc_data is stable while trc_vd & ~trc_rdy. The next entry appears the cycle after a pop.
- Throughput: one push and one pop per cycle.
- No combinational path from trc_rdy to trc_vd or trc_data.

## Configuration
- SCR1_TRACE_TIMESTAMP_EN defined:
  - A free-running 32-bit cycle counter is included. It is reset to 0, increments every cycle and wraps at 0xFFFFFFFF -> 0.
  - Record width is 104. Bits [103:72] hold the counter value in the event (or marker push) cycle.
- Undefined: no counter is included and the record width is 72.

## Test plan
- Single event: reset, trace_en = 1, trc_rdy = 1; cycle 5 drive update_pc_en, update_pc = 0x200, mprf_wr_en, addr = 10, data = 0xDEADBEEF -> cycle 6 trc_vd = 1, trc_data = {0,0,1,5'd10,0xDEADBEEF,0x200}.
- x0 write: mprf_wr_addr = 0, data = 0x1234, update_pc = 0x204 -> record wr_flag = 0, addr/data fields 0, pc field 0x204.
- Overflow: FIFO_DEPTH = 8, trc_rdy = 0, 11 consecutive events -> 8 stored, trc_ovf_sticky = 1. Then trc_rdy = 1 for 1 cycle, with 1 more event in the cycle after the pop -> 9th record is a marker with [31:0] = 4, followed by no further records.
- Full with simultaneous pop: occupancy 8, pop and event in same cycle -> event dropped, occupancy 7, state OVF.
- Reset mid-stream: 5 records queued, assert rst_n low for 1 cycle -> trc_vd = 0, trc_data = 0; the next event appears as the sole record.
- Timestamp (macro defined): event in cycle 100 after reset release -> [103:72] = 100. Force the counter to 0xFFFFFFFF -> next cycle reads 0.

Source files
------------

// File: rtl/scr1_trace_buf.sv
// rtl/scr1_trace_buf.sv - SCR1 commit-trace record FIFO with overflow marker
// Optional SCR1_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp in record bits [103:72].
module scr1_trace_buf #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         trace_en,
  input  logic         update_pc_en,
  input  logic [31:0]  update_pc,
  input  logic         mprf_wr_en,
  input  logic [4:0]   mprf_wr_addr,
  input  logic [31:0]  mprf_wr_data,
  output logic         trc_vd,
  input  logic         trc_rdy,
`ifdef SCR1_TRACE_TIMESTAMP_EN
  output logic [103:0] trc_data,
`else
  output logic [71:0]  trc_data,
`endif
  output logic         trc_ovf_sticky,
  input  logic         trc_ovf_clr
);

`ifdef SCR1_TRACE_TIMESTAMP_EN
  localparam int REC_W = 104;
`else
  localparam int REC_W = 72;
`endif
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_OVF    = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      drop_cnt;
  logic [15:0]      drop_cnt_nxt;
  logic [15:0]      drop_cnt_inc;
  logic [15:0]      mark_cnt;
  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             evt;
  logic             space;
  logic             push;
  logic             pop;
  logic             drop;
  logic             wr_flag;
  logic [71:0]      evt_base;
  logic [71:0]      mark_base;
  logic [REC_W-1:0] evt_rec;
  logic [REC_W-1:0] mark_rec;
  logic [REC_W-1:0] push_rec;

  assign evt     = trace_en & (update_pc_en | mprf_wr_en);
  // Space is judged on start-of-cycle occupancy; a same-cycle pop never frees a slot.
  assign space   = (count < CNT_W'(FIFO_DEPTH));
  assign trc_vd  = (count != '0);
  assign pop     = trc_vd & trc_rdy;
  assign wr_flag = mprf_wr_en & (mprf_wr_addr != 5'd0);

  assign drop_cnt_inc = (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
  assign mark_cnt     = evt ? drop_cnt_inc : drop_cnt;

  assign evt_base  = {1'b0, 1'b0, wr_flag,
                      wr_flag ? mprf_wr_addr : 5'd0,
                      wr_flag ? mprf_wr_data : 32'd0,
                      update_pc};
  assign mark_base = {1'b0, 1'b1, 38'd0, 16'd0, mark_cnt};

`ifdef SCR1_TRACE_TIMESTAMP_EN
  logic [31:0] tstamp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tstamp <= 32'd0;
    end else begin
      tstamp <= tstamp + 32'd1;
    end
  end

  assign evt_rec  = {tstamp, evt_base};
  assign mark_rec = {tstamp, mark_base};
`else
  assign evt_rec  = evt_base;
  assign mark_rec = mark_base;
`endif

  always_comb begin
    state_nxt    = state;
    drop_cnt_nxt = drop_cnt;
    push         = 1'b0;
    push_rec     = evt_rec;
    drop         = 1'b0;
    case (state)
      ST_NORMAL: begin
        if (evt) begin
          if (space) begin
            push = 1'b1;
          end else begin
            drop         = 1'b1;
            drop_cnt_nxt = 16'd1;
            state_nxt    = ST_OVF;
          end
        end
      end
      ST_OVF: begin
        // The marker wins the free slot; a coincident event is dropped and counted in it.
        if (space) begin
          push         = 1'b1;
          push_rec     = mark_rec;
          drop         = evt;
          drop_cnt_nxt = 16'd0;
          state_nxt    = ST_NORMAL;
        end else if (evt) begin
          drop         = 1'b1;
          drop_cnt_nxt = drop_cnt_inc;
        end
      end
      default: begin
        state_nxt = ST_NORMAL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_NORMAL;
      drop_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trc_ovf_sticky <= 1'b0;
    end else if (drop) begin
      trc_ovf_sticky <= 1'b1;
    end else if (trc_ovf_clr) begin
      trc_ovf_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_rec;
    end
  end

  assign trc_data = trc_vd ? mem[rd_ptr] : '0;

endmodule
